fetch_ctrl: RTL and testbench

Fetch sequencer for the instruction memory block, which takes a word index and returns the 32-bit word one clock later. Owns the program counter, issues one memory read per cycle while buffer credit allows, and captures the returned words into a 2-entry buffer. Presents {pc, instruction} to decode over a valid/ready handshake. Applies redirects from execute (branches and jumps) and discards stale data.

---
 rtl/fetch_pkg.sv | 12 +
 rtl/fetch_buf.sv | 55 +++++
 rtl/fetch_ctrl.sv | 69 ++++++
 tb/tb_fetch_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_pkg;
  localparam int FETCH_BUF_DEPTH = 2;
  localparam int INSTR_BYTES     = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} holding fetched words until decode takes them.
// Latency: a push is visible at the head after the next edge.
// Backpressure: no full check; the caller's credit rule never pushes while full.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push,
  input  logic [31:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  input  logic        flush,
  output logic [1:0]  count,
  output logic [31:0] head_pc,
  output logic [31:0] head_instr
);
  fetch_entry_t mem_q [FETCH_BUF_DEPTH];
  logic         rd_ptr_q;
  logic         wr_ptr_q;
  logic [1:0]   count_q;

  // One-bit pointers wrap naturally because the depth is two.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{pc: push_pc, instr: push_instr};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count      = count_q;
  assign head_pc    = mem_q[rd_ptr_q].pc;
  assign head_instr = mem_q[rd_ptr_q].instr;
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues one read per cycle and buffers returned words.
// Latency: 2 cycles from issue to valid_o; redirect target valid 2 edges after redirect.
// Backpressure: ready_i low holds the head; issue stops once buffered + in-flight reaches 2.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] mem_addr_o,
  input  logic [31:0] mem_instr_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  input  logic        ready_i
);
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic        inflight_q;
  logic [31:0] issue_pc;
  logic [2:0]  credit_use;
  logic [1:0]  count;
  logic        pop;
  logic        push;
  logic        issue;

  always_comb begin
    issue_pc   = redirect_i ? (redirect_pc_i & ~32'h3) : pc_q;
    pop        = valid_o && ready_i && !redirect_i;
    // Slots already claimed next cycle: buffered words plus the read in flight, minus the pop.
    credit_use = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
    issue      = !redirect_i && (credit_use < 3'(FETCH_BUF_DEPTH));
    push       = inflight_q && !redirect_i;
  end

  assign mem_addr_o = {2'b00, issue_pc[31:2]};
  assign valid_o    = (count != 2'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q       <= RESET_PC;
      pend_pc_q  <= 32'h0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue | redirect_i;
      if (issue || redirect_i) begin
        pc_q      <= issue_pc + 32'(INSTR_BYTES);
        pend_pc_q <= issue_pc;
      end
    end
  end

  // A redirect flushes the buffer and drops the word returning this cycle.
  fetch_buf u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push       (push),
    .push_pc    (pend_pc_q),
    .push_instr (mem_instr_i),
    .pop        (pop),
    .flush      (redirect_i),
    .count      (count),
    .head_pc    (pc_o),
    .head_instr (instr_o)
  );
endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: queue-based reference model, per-cycle compare, directed and random stimulus.
module tb_fetch_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_instr_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        ready_i = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .mem_addr_o    (mem_addr_o),
    .mem_instr_i   (mem_instr_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .ready_i       (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory word i holds 32'h1000_0000 + i; 12-bit word index.
  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'h1000_0000 + {20'h0, pc[13:2]};
  endfunction

  always @(posedge clk_i) mem_instr_i <= 32'h1000_0000 + {20'h0, mem_addr_o[11:0]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the PCs sitting in the buffer, the one read in flight, and the next PC to fetch.
  logic [31:0] mq[$];
  bit          m_fl = 1'b0;
  logic [31:0] m_fl_pc = 32'h0;
  logic [31:0] m_npc = 32'h0;

  always @(posedge clk_i or posedge rst_i) begin
    int occ;
    bit take, iss;
    if (rst_i) begin
      mq.delete();
      m_fl  = 1'b0;
      m_npc = 32'h0;
    end else if (redirect_i) begin
      mq.delete();
      m_fl    = 1'b1;
      m_fl_pc = redirect_pc_i & ~32'h3;
      m_npc   = m_fl_pc + 32'd4;
    end else begin
      occ  = mq.size();
      take = (occ != 0) && ready_i;
      iss  = (occ + int'(m_fl) - int'(take)) < 2;
      if (take) void'(mq.pop_front());
      if (m_fl) mq.push_back(m_fl_pc);
      if (iss) begin
        m_fl_pc = m_npc;
        m_npc   = m_npc + 32'd4;
      end
      m_fl = iss;
    end
  end

  always @(negedge clk_i) begin
    check("mem_addr", mem_addr_o,
          redirect_i ? {2'b00, redirect_pc_i[31:2]} : {2'b00, m_npc[31:2]});
    check("valid", {31'h0, valid_o}, {31'h0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("pc", pc_o, mq[0]);
      check("instr", instr_o, word_at(mq[0]));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic head_is(input string name, input logic v, input logic [31:0] pc);
    check({name, "_valid"}, {31'h0, valid_o}, {31'h0, v});
    if (v) begin
      check({name, "_pc"}, pc_o, pc);
      check({name, "_instr"}, instr_o, word_at(pc));
    end
  endtask

  initial begin
    // Reset and stream
    repeat (3) @(posedge clk_i);
    #2;
    head_is("reset", 1'b0, 32'h0);
    check("reset_pc_o", pc_o, 32'h0);
    check("reset_instr_o", instr_o, 32'h0);
    rst_i = 1'b0;
    #1 check("first_addr", mem_addr_o, 32'h0);
    tick(); head_is("lat1", 1'b0, 32'h0);
    tick(); head_is("lat2", 1'b1, 32'h0);
    check("first_instr", instr_o, 32'h1000_0000);
    tick(); head_is("s1", 1'b1, 32'h4);
    check("second_instr", instr_o, 32'h1000_0001);
    tick(); head_is("s2", 1'b1, 32'h8);

    // Backpressure
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); head_is("stall", 1'b1, 32'h8);
    end
    ready_i = 1'b1;
    tick(); head_is("resume1", 1'b1, 32'hC);
    tick(); head_is("resume2", 1'b1, 32'h10);

    // Redirect with a full buffer
    ready_i = 1'b0;
    repeat (2) tick();
    redirect_i = 1'b1; redirect_pc_i = 32'h40;
    tick();
    redirect_i = 1'b0; ready_i = 1'b1;
    head_is("redir_flush", 1'b0, 32'h0);
    tick(); head_is("redir_tgt", 1'b1, 32'h40);
    tick(); head_is("redir_next", 1'b1, 32'h44);

    // Back-to-back redirects
    redirect_i = 1'b1; redirect_pc_i = 32'h100;
    tick();
    redirect_pc_i = 32'h200;
    tick();
    redirect_i = 1'b0;
    head_is("b2b_gap", 1'b0, 32'h0);
    tick(); head_is("b2b_first", 1'b1, 32'h200);
    tick(); head_is("b2b_next", 1'b1, 32'h204);

    // Misaligned target and PC wrap
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    tick(); head_is("wrap_hi", 1'b1, 32'hFFFF_FFFC);
    check("wrap_hi_word", instr_o, 32'h1000_0FFF);
    tick(); head_is("wrap_zero", 1'b1, 32'h0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      tick();
      ready_i       = ($urandom_range(0, 9) < 7);
      redirect_i    = ($urandom_range(0, 19) == 0);
      redirect_pc_i = $urandom();
    end

    // Async reset with a full buffer
    redirect_i = 1'b0; ready_i = 1'b1;
    repeat (4) tick();
    ready_i = 1'b0;
    repeat (3) tick();
    check("pre_reset_valid", {31'h0, valid_o}, 32'h1);
    #1 rst_i = 1'b1;
    #1 head_is("async_rst", 1'b0, 32'h0);
    check("async_rst_pc_o", pc_o, 32'h0);
    check("async_rst_instr_o", instr_o, 32'h0);
    repeat (2) tick();
    rst_i = 1'b0; ready_i = 1'b1;
    #1 check("restart_addr", mem_addr_o, 32'h0);
    tick(); head_is("restart_lat", 1'b0, 32'h0);
    tick(); head_is("restart0", 1'b1, 32'h0);
    tick(); head_is("restart1", 1'b1, 32'h4);

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
